// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - PC register and 64-bit fetch request stage with one-entry output buffer
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush_req,
  input  logic        exception_pc_ena,
  output logic [31:0] pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        if_valid,
  output logic        if_valid1,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst0,
  output logic [31:0] if_inst1,
  input  logic        if_ready
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic        cancel;
  logic [31:0] req_pc;
  logic        redirect;
  logic        drain;
  logic        fill;

  assign redirect  = flush_req | exception_pc_ena;
  assign drain     = if_valid & if_ready;
  assign fill      = (state == S_WAIT) & inst_data_ok & ~cancel;
  assign inst_addr = {pc[31:3], 3'b000};

  // A new fetch only goes out when the buffer will be empty by the time data returns.
  assign inst_req = ~rst & (state == S_REQ) & ~redirect & (~if_valid | if_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      cancel    <= 1'b0;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      if_valid  <= 1'b0;
      if_valid1 <= 1'b0;
      if_pc     <= 32'h0;
      if_inst0  <= 32'h0;
      if_inst1  <= 32'h0;
    end else if (redirect) begin
      pc        <= next_pc;
      if_valid  <= 1'b0;
      if_valid1 <= 1'b0;
      // The outstanding response is either absorbed now or marked for discard.
      if (state == S_WAIT) begin
        if (inst_data_ok) begin
          state  <= S_REQ;
          cancel <= 1'b0;
        end else begin
          cancel <= 1'b1;
        end
      end
    end else begin
      case (state)
        S_REQ: begin
          if (inst_req && inst_addr_ok) begin
            req_pc <= pc;
            pc     <= next_pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            cancel <= 1'b0;
            state  <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (fill) begin
        if_valid  <= 1'b1;
        if_valid1 <= ~req_pc[2];
        if_pc     <= req_pc;
        if_inst0  <= req_pc[2] ? inst_rdata[63:32] : inst_rdata[31:0];
        if_inst1  <= inst_rdata[63:32];
      end else if (drain) begin
        if_valid  <= 1'b0;
        if_valid1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        flush_req;
  logic        exception_pc_ena;
  logic [31:0] pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        if_valid;
  logic        if_valid1;
  logic [31:0] if_pc;
  logic [31:0] if_inst0;
  logic [31:0] if_inst1;
  logic        if_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .next_pc          (next_pc),
    .flush_req        (flush_req),
    .exception_pc_ena (exception_pc_ena),
    .pc               (pc),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .if_valid         (if_valid),
    .if_valid1        (if_valid1),
    .if_pc            (if_pc),
    .if_inst0         (if_inst0),
    .if_inst1         (if_inst1),
    .if_ready         (if_ready)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    next_pc = 32'h0;
    flush_req = 1'b0;
    exception_pc_ena = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 64'h0;
    if_ready = 1'b1;

    // reset state
    tick();
    tick();
    settle();
    check("rst_inst_req", inst_req, 1'b0);
    check("rst_pc", pc, 32'hBFC0_0000);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_valid1", if_valid1, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst0", if_inst0, 32'h0);
    check("rst_if_inst1", if_inst1, 32'h0);

    // 1: zero-wait fetch from the reset vector
    rst = 1'b0;
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0008;
    settle();
    check("t1_req", inst_req, 1'b1);
    check("t1_addr", inst_addr, 32'hBFC0_0000);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 64'h2222_2222_1111_1111;
    settle();
    check("t1_wait_req", inst_req, 1'b0);
    check("t1_pc_adv", pc, 32'hBFC0_0008);
    tick();
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0010;
    settle();
    check("t1_valid", if_valid, 1'b1);
    check("t1_valid1", if_valid1, 1'b1);
    check("t1_if_pc", if_pc, 32'hBFC0_0000);
    check("t1_inst0", if_inst0, 32'h1111_1111);
    check("t1_inst1", if_inst1, 32'h2222_2222);
    check("t1_next_req", inst_req, 1'b1);
    check("t1_next_addr", inst_addr, 32'hBFC0_0008);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 64'h6666_6666_5555_5555;
    settle();
    check("t1_drained", if_valid, 1'b0);
    tick();
    inst_data_ok = 1'b0;
    settle();
    check("t1_fill2_pc", if_pc, 32'hBFC0_0008);
    check("t1_fill2_inst0", if_inst0, 32'h5555_5555);

    // redirect in REQ to reach the odd-word PC for step 2
    if_ready = 1'b0;
    flush_req = 1'b1;
    next_pc = 32'hBFC0_0004;
    settle();
    check("t2_flush_req0", inst_req, 1'b0);
    tick();
    flush_req = 1'b0;
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0008;
    settle();
    check("t2_cleared", if_valid, 1'b0);
    check("t2_pc", pc, 32'hBFC0_0004);
    check("t2_req", inst_req, 1'b1);
    check("t2_addr", inst_addr, 32'hBFC0_0000);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
    tick();
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    settle();
    check("t2_valid", if_valid, 1'b1);
    check("t2_valid1", if_valid1, 1'b0);
    check("t2_if_pc", if_pc, 32'hBFC0_0004);
    check("t2_inst0", if_inst0, 32'hBBBB_BBBB);
    check("t2_pc_next", pc, 32'hBFC0_0008);

    // 3: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t3_stall_req", inst_req, 1'b0);
      check("t3_hold_valid", if_valid, 1'b1);
      check("t3_hold_pc", if_pc, 32'hBFC0_0004);
      check("t3_hold_inst0", if_inst0, 32'hBBBB_BBBB);
      tick();
    end
    if_ready = 1'b1;
    next_pc = 32'hBFC0_0010;
    settle();
    check("t3_resume_req", inst_req, 1'b1);
    check("t3_resume_addr", inst_addr, 32'hBFC0_0008);
    tick();
    inst_addr_ok = 1'b0;
    settle();
    check("t3_drained", if_valid, 1'b0);

    // 4: flush while waiting, late data discarded
    flush_req = 1'b1;
    next_pc = 32'h8000_1000;
    tick();
    flush_req = 1'b0;
    next_pc = 32'h8000_1008;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t4_wait_req", inst_req, 1'b0);
      check("t4_wait_valid", if_valid, 1'b0);
      tick();
    end
    inst_data_ok = 1'b1;
    inst_rdata = 64'hDEAD_DEAD_BEEF_BEEF;
    settle();
    check("t4_pc", pc, 32'h8000_1000);
    tick();
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    settle();
    check("t4_discarded", if_valid, 1'b0);
    check("t4_req", inst_req, 1'b1);
    check("t4_addr", inst_addr, 32'h8000_1000);
    tick();

    // 5: exception coincident with data_ok, then with a full buffer
    inst_addr_ok = 1'b0;
    exception_pc_ena = 1'b1;
    next_pc = 32'hBFC0_0380;
    inst_data_ok = 1'b1;
    inst_rdata = 64'h9999_9999_8888_8888;
    settle();
    check("t5_exc_req", inst_req, 1'b0);
    tick();
    exception_pc_ena = 1'b0;
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0388;
    settle();
    check("t5_dropped", if_valid, 1'b0);
    check("t5_pc", pc, 32'hBFC0_0380);
    check("t5_req_next", inst_req, 1'b1);
    check("t5_addr", inst_addr, 32'hBFC0_0380);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 64'hDDDD_DDDD_CCCC_CCCC;
    tick();
    inst_data_ok = 1'b0;
    if_ready = 1'b0;
    settle();
    check("t5_fill_valid", if_valid, 1'b1);
    check("t5_fill_inst0", if_inst0, 32'hCCCC_CCCC);
    exception_pc_ena = 1'b1;
    next_pc = 32'hBFC0_0380;
    settle();
    check("t5_exc2_req", inst_req, 1'b0);
    tick();
    exception_pc_ena = 1'b0;
    if_ready = 1'b1;
    settle();
    check("t5_buf_cleared", if_valid, 1'b0);
    check("t5_buf_cleared1", if_valid1, 1'b0);

    // 6: reset while waiting with a cancel pending
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0388;
    settle();
    check("t6_req", inst_req, 1'b1);
    tick();
    inst_addr_ok = 1'b0;
    flush_req = 1'b1;
    next_pc = 32'h1234_5678;
    tick();
    flush_req = 1'b0;
    settle();
    check("t6_cancel_set", dut.cancel, 1'b1);
    rst = 1'b1;
    settle();
    check("t6_rst_req", inst_req, 1'b0);
    tick();
    settle();
    check("t6_rst_pc", pc, 32'hBFC0_0000);
    check("t6_rst_cancel", dut.cancel, 1'b0);
    check("t6_rst_valid", if_valid, 1'b0);
    rst = 1'b0;
    inst_addr_ok = 1'b1;
    next_pc = 32'hBFC0_0008;
    settle();
    check("t6_restart_req", inst_req, 1'b1);
    check("t6_restart_addr", inst_addr, 32'hBFC0_0000);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata = 64'h4444_4444_3333_3333;
    tick();
    inst_data_ok = 1'b0;
    settle();
    check("t6_fill_valid", if_valid, 1'b1);
    check("t6_fill_pc", if_pc, 32'hBFC0_0000);
    check("t6_fill_inst0", if_inst0, 32'h3333_3333);
    check("t6_fill_inst1", if_inst1, 32'h4444_4444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
